// File: rtl/pwm_duty_decoder_pkg.sv
`default_nettype none
// ============================================================
// Package : pwm_duty_decoder_pkg
// Shared widths, FSM encoding and step rounding helper.
// Rev     : 1.0
// ============================================================
package pwm_duty_decoder_pkg;

    localparam int STEP_W           = 6;
    localparam int DUTY_W           = 4;
    localparam int PERIOD_STEPS_DEF = 16;

    localparam logic [1:0] ST_ESPERA = 2'd0;
    localparam logic [1:0] ST_ALTO   = 2'd1;
    localparam logic [1:0] ST_BAJO   = 2'd2;

    // Adds the round-half-up step while keeping the 63-step saturation.
    function automatic logic [STEP_W-1:0] sat_round(input logic [STEP_W-1:0] steps,
                                                    input logic              up);
        if (up && (steps != {STEP_W{1'b1}}))
            return steps + STEP_W'(1);
        return steps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sincronizador_flanco.sv
`default_nettype none
// ============================================================
// Module : sincronizador_flanco
// Two-flop synchronizer with rise/fall pulse detection.
// Rev    : 1.0
// ============================================================
module sincronizador_flanco (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic nivel_o,
    output logic sube_o,
    output logic baja_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign nivel_o = sync_q;
    assign sube_o  = sync_q & ~prev_q;
    assign baja_o  = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_decoder.sv
`default_nettype none
// ============================================================
// Module : pwm_duty_decoder
// Measures PWM high time and period in steps, reports duty.
// Rev    : 1.0
// ============================================================
module pwm_duty_decoder
    import pwm_duty_decoder_pkg::*;
#(
    parameter int TICKS_PER_STEP = 1000,
    parameter int PERIOD_STEPS   = PERIOD_STEPS_DEF,
    parameter int PERIOD_TOL     = 1,
    parameter int TIMEOUT_STEPS  = 40
) (
    input  logic              clk_100MHz,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] ciclo_medido,
    output logic              medicion_valida,
    output logic              error_periodo,
    output logic              nivel_constante
);

    localparam int               SUB_W    = $clog2(TICKS_PER_STEP);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_STEP - 1);

    logic              nivel_w, sube_w, baja_w;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] idle_q, idle_d;
    logic [STEP_W-1:0] high_q, high_d;
    logic [1:0]        state_q, state_d;
    logic [DUTY_W-1:0] ciclo_q, ciclo_d;
    logic              valida_q, valida_d;
    logic              err_q, err_d;
    logic              nivel_q, nivel_d;

    logic              edge_w, wrap_w, up_w, timeout_w, period_ok_w;
    logic [STEP_W-1:0] rounded_w;
    int                delta_w;

    sincronizador_flanco u_sync (
        .clk_i  (clk_100MHz),
        .rst_i  (rst),
        .d_i    (pwm_in),
        .nivel_o(nivel_w),
        .sube_o (sube_w),
        .baja_o (baja_w)
    );

    assign edge_w = sube_w | baja_w;
    assign wrap_w = (sub_q == SUB_LAST);
    // The edge cycle itself belongs to the interval, hence sub+1 when rounding.
    assign up_w        = (int'(sub_q) + 1) >= (TICKS_PER_STEP / 2);
    assign rounded_w   = sat_round(step_q, up_w);
    assign delta_w     = int'(rounded_w) - PERIOD_STEPS;
    assign period_ok_w = (delta_w <= PERIOD_TOL) && (delta_w >= -PERIOD_TOL);
    assign timeout_w   = wrap_w && !edge_w && (idle_q == STEP_W'(TIMEOUT_STEPS - 1));

    always_comb begin
        sub_d    = (edge_w || wrap_w) ? '0 : sub_q + SUB_W'(1);
        step_d   = (wrap_w && (step_q != {STEP_W{1'b1}})) ? step_q + STEP_W'(1) : step_q;
        idle_d   = idle_q;
        high_d   = high_q;
        state_d  = state_q;
        ciclo_d  = ciclo_q;
        valida_d = 1'b0;
        err_d    = 1'b0;
        nivel_d  = nivel_q & ~edge_w;

        if (edge_w)
            idle_d = '0;
        else if (wrap_w && (idle_q != STEP_W'(TIMEOUT_STEPS)))
            idle_d = idle_q + STEP_W'(1);

        case (state_q)
            ST_ESPERA: begin
                if (sube_w) begin
                    step_d  = '0;
                    state_d = ST_ALTO;
                end
            end
            ST_ALTO: begin
                // Period count resumes from the rounded high time so no fraction is lost.
                if (baja_w) begin
                    high_d  = rounded_w;
                    step_d  = rounded_w;
                    state_d = ST_BAJO;
                end
            end
            ST_BAJO: begin
                if (sube_w) begin
                    if (period_ok_w) begin
                        ciclo_d  = (high_q > STEP_W'(15)) ? 4'hF : high_q[DUTY_W-1:0];
                        valida_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    step_d  = '0;
                    state_d = ST_ALTO;
                end
            end
            default: state_d = ST_ESPERA;
        endcase

        if (timeout_w) begin
            nivel_d  = 1'b1;
            ciclo_d  = nivel_w ? 4'hF : 4'h0;
            valida_d = 1'b1;
            state_d  = ST_ESPERA;
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            sub_q    <= '0;
            step_q   <= '0;
            idle_q   <= '0;
            high_q   <= '0;
            state_q  <= ST_ESPERA;
            ciclo_q  <= '0;
            valida_q <= 1'b0;
            err_q    <= 1'b0;
            nivel_q  <= 1'b0;
        end else begin
            sub_q    <= sub_d;
            step_q   <= step_d;
            idle_q   <= idle_d;
            high_q   <= high_d;
            state_q  <= state_d;
            ciclo_q  <= ciclo_d;
            valida_q <= valida_d;
            err_q    <= err_d;
            nivel_q  <= nivel_d;
        end
    end

    assign ciclo_medido    = ciclo_q;
    assign medicion_valida = valida_q;
    assign error_periodo   = err_q;
    assign nivel_constante = nivel_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
`default_nettype none
// ============================================================
// Module : tb_pwm_duty_decoder
// Scoreboard bench for pwm_duty_decoder (TICKS_PER_STEP=4).
// Rev    : 1.0
// ============================================================
module tb_pwm_duty_decoder;

    localparam int K_NONE = 0;
    localparam int K_VAL  = 1;
    localparam int K_ERR  = 2;
    localparam int K_TMO  = 3;

    logic       clk_100MHz = 1'b0;
    logic       rst        = 1'b1;
    logic       pwm_in     = 1'b0;
    logic [3:0] ciclo_medido;
    logic       medicion_valida;
    logic       error_periodo;
    logic       nivel_constante;

    pwm_duty_decoder #(
        .TICKS_PER_STEP(4),
        .PERIOD_STEPS  (16),
        .PERIOD_TOL    (1),
        .TIMEOUT_STEPS (40)
    ) dut (
        .clk_100MHz     (clk_100MHz),
        .rst            (rst),
        .pwm_in         (pwm_in),
        .ciclo_medido   (ciclo_medido),
        .medicion_valida(medicion_valida),
        .error_periodo  (error_periodo),
        .nivel_constante(nivel_constante)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Rows: high cycles, low cycles, and the report expected for the period the rise closes.
    int row_hi   [16] = '{20, 20, 20, 22, 22, 21, 21, 20, 20, 60, 60,  4,  4, 40, 40, 40};
    int row_lo   [16] = '{44, 44, 44, 42, 42, 43, 43, 60, 60,  4,  4, 60, 60, 24, 24, 24};
    int row_kind [16] = '{K_NONE, K_VAL, K_VAL, K_VAL, K_VAL, K_VAL, K_VAL, K_VAL,
                          K_ERR, K_ERR, K_VAL, K_VAL, K_VAL, K_VAL, K_VAL, K_VAL};
    int row_val  [16] = '{0, 5, 5, 5, 6, 6, 5, 5, 5, 5, 15, 15, 1, 1, 10, 10};

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    task automatic rise(input int kind, input int val);
        exp_t e;
        pwm_in = 1'b1;
        if (kind != K_NONE) begin
            e.kind = kind;
            e.val  = val;
            e.cyc  = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic run_row(input int i);
        rise(row_kind[i], row_val[i]);
        wait_cyc(row_hi[i]);
        pwm_in = 1'b0;
        wait_cyc(row_lo[i]);
    endtask

    task automatic push_timeout(input int val);
        exp_t e;
        e.kind = K_TMO;
        e.val  = val;
        e.cyc  = -1;
        sb.push_back(e);
    endtask

    always @(negedge clk_100MHz) begin
        exp_t e;
        if (!rst && (medicion_valida || error_periodo)) begin
            chk("pulse_exclusive", int'(medicion_valida && error_periodo), 0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", error_periodo ? K_ERR : K_VAL,
                    (e.kind == K_ERR) ? K_ERR : K_VAL);
                chk("ciclo_medido", int'(ciclo_medido), e.val);
                if (e.cyc >= 0)
                    chk("latency_cycle", cyc, e.cyc);
                if (e.kind == K_TMO)
                    chk("nivel_at_timeout", int'(nivel_constante), 1);
            end
        end
    end

    initial begin
        wait_cyc(3);
        chk("reset_ciclo", int'(ciclo_medido), 0);
        chk("reset_valida", int'(medicion_valida), 0);
        chk("reset_error", int'(error_periodo), 0);
        chk("reset_nivel", int'(nivel_constante), 0);
        rst = 1'b0;

        // Constant low from reset release.
        push_timeout(0);
        wait_cyc(175);
        chk("low_nivel", int'(nivel_constante), 1);
        chk("low_ciclo", int'(ciclo_medido), 0);

        run_row(0);
        chk("rise_clears_nivel", int'(nivel_constante), 0);
        for (int i = 1; i < 15; i++)
            run_row(i);

        // Duty 10 running; async reset lands mid-high.
        rise(row_kind[15], row_val[15]);
        wait_cyc(20);
        chk("pre_reset_ciclo", int'(ciclo_medido), 10);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ciclo", int'(ciclo_medido), 0);
        chk("async_rst_valida", int'(medicion_valida), 0);
        chk("async_rst_error", int'(error_periodo), 0);
        chk("async_rst_nivel", int'(nivel_constante), 0);
        pwm_in = 1'b0;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(4);

        rise(K_NONE, 0);
        wait_cyc(40);
        pwm_in = 1'b0;
        wait_cyc(24);
        chk("no_report_partial", int'(ciclo_medido), 0);
        rise(K_VAL, 10);
        wait_cyc(40);
        pwm_in = 1'b0;
        wait_cyc(24);

        // Constant high: this rise closes the last duty-10 period.
        rise(K_VAL, 10);
        push_timeout(15);
        wait_cyc(200);
        chk("high_nivel", int'(nivel_constante), 1);
        chk("high_ciclo", int'(ciclo_medido), 15);
        pwm_in = 1'b0;
        wait_cyc(5);
        chk("edge_clears_nivel", int'(nivel_constante), 0);
        chk("ciclo_holds_after_edge", int'(ciclo_medido), 15);
        wait_cyc(10);

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
